poci_arbiter: RTL and testbench

- Two-requester arbiter for the POCI (APB-style) peripheral bus; shares one downstream slave port between two upstream masters.
- Each requester connects to an if_poci.f modport; the arbiter drives one if_poci.n modport towards the shared peripheral/decoder.
- Round-robin grant, one transfer at a time, with an optional watchdog that terminates hung transfers with an error response.

---
 rtl/poci_arbiter_if.sv | 20 ++
 rtl/poci_arbiter.sv | 124 ++++++++++++
 tb/tb_poci_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/poci_arbiter_if.sv
// rtl/poci_arbiter_if.sv - POCI bus widths and the requester/downstream bus bundle
package pk_poci;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

interface if_poci;
    logic                            psel;
    logic                            penable;
    logic                            pwrite;
    logic [pk_poci::ADDR_WIDTH-1:0]  paddr;
    logic [pk_poci::DATA_WIDTH-1:0]  pwdata;
    logic [pk_poci::DATA_WIDTH-1:0]  prdata;
    logic                            pready;
    logic                            pslverr;

    // f: the arbiter faces a requester; n: the arbiter drives the shared port
    modport f (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
    modport n (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
endinterface

// File: rtl/poci_arbiter.sv
// rtl/poci_arbiter.sv - two-requester round-robin POCI arbiter with ACCESS-phase watchdog
module poci_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    if_poci.f          m0,
    if_poci.f          m1,
    if_poci.n          s,
    output logic [1:0] grant
);
    localparam int AW = pk_poci::ADDR_WIDTH;
    localparam int DW = pk_poci::DATA_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam bit                   WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;
    logic [AW-1:0]        paddr_q, paddr_d;
    logic [DW-1:0]        pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;
    logic [CNT_WIDTH-1:0] wd_q, wd_d;

    logic          in_access;
    logic          wd_fire;
    logic          done;
    logic          pick_m1;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;
    logic          unused_penable;

    // Requester penable is irrelevant: a stalled ACCESS still counts as pending
    assign unused_penable = m0.penable | m1.penable;

    always_comb begin
        in_access = (state_q == ST_ACCESS);
        wd_fire   = WD_EN && in_access && !s.pready && (wd_q == WD_LAST);
        done      = in_access && (s.pready || wd_fire);
        rsp_err   = s.pready ? s.pslverr : 1'b1;
        rsp_data  = s.pready ? s.prdata : '0;
        // last_q = 1 means m1 owned the previous transfer
        pick_m1   = m1.psel && (!m0.psel || !last_q);
    end

    assign s.psel    = (state_q != ST_IDLE);
    assign s.penable = in_access;
    assign s.paddr   = paddr_q;
    assign s.pwrite  = pwrite_q;
    assign s.pwdata  = pwdata_q;

    assign m0.pready  = done && grant_q[0];
    assign m0.pslverr = done && grant_q[0] && rsp_err;
    assign m0.prdata  = (done && grant_q[0]) ? rsp_data : '0;
    assign m1.pready  = done && grant_q[1];
    assign m1.pslverr = done && grant_q[1] && rsp_err;
    assign m1.prdata  = (done && grant_q[1]) ? rsp_data : '0;

    assign grant = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        wd_d     = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.psel || m1.psel) begin
                    state_d  = ST_SETUP;
                    grant_d  = pick_m1 ? 2'b10 : 2'b01;
                    paddr_d  = pick_m1 ? m1.paddr : m0.paddr;
                    pwdata_d = pick_m1 ? m1.pwdata : m0.pwdata;
                    pwrite_d = pick_m1 ? m1.pwrite : m0.pwrite;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wd_d    = '0;
            end
            ST_ACCESS: begin
                if (done) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q[1];
                    grant_d = 2'b00;
                end else begin
                    wd_d = wd_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            wd_q     <= wd_d;
        end
    end
endmodule

// File: tb/tb_poci_arbiter.sv
// tb/tb_poci_arbiter.sv - directed self-checking bench for poci_arbiter
module tb_poci_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       reset0;
    logic [1:0] grant;
    logic [1:0] grant0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    if_poci m0();
    if_poci m1();
    if_poci s();
    if_poci z0();
    if_poci z1();
    if_poci zs();

    poci_arbiter #(.TIMEOUT(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .m0(m0), .m1(m1), .s(s), .grant(grant)
    );

    poci_arbiter #(.TIMEOUT(0), .CNT_WIDTH(8)) dut_nowd (
        .clk(clk), .reset(reset0), .m0(z0), .m1(z1), .s(zs), .grant(grant0)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0.psel = 0; m0.penable = 0; m0.pwrite = 0; m0.paddr = '0; m0.pwdata = '0;
        m1.psel = 0; m1.penable = 0; m1.pwrite = 0; m1.paddr = '0; m1.pwdata = '0;
        s.pready = 0; s.pslverr = 0; s.prdata = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle_inputs();
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        m0.psel = 1; m1.psel = 1; s.pready = 1; s.prdata = 32'hFFFF_FFFF;
        cyc(); #2;
        tests++; if (s.psel !== 1'b0) begin fails++; $display("FAIL rst_psel got=%b exp=0", s.psel); end
        tests++; if (s.penable !== 1'b0) begin fails++; $display("FAIL rst_penable got=%b exp=0", s.penable); end
        tests++; if ({s.pwrite, s.paddr, s.pwdata} !== 65'd0) begin fails++; $display("FAIL rst_payload got=%b/%h/%h exp=0", s.pwrite, s.paddr, s.pwdata); end
        tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rst_grant got=%b exp=00", grant); end
        tests++; if ({m0.pready, m0.pslverr, m0.prdata, m1.pready, m1.pslverr, m1.prdata} !== 68'd0) begin
            fails++; $display("FAIL rst_rsp got=%b%b%h %b%b%h exp=0", m0.pready, m0.pslverr, m0.prdata, m1.pready, m1.pslverr, m1.prdata);
        end
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        m0.psel = 1; m0.paddr = 32'h10; m0.pwrite = 0;
        s.pready = 1; s.prdata = 32'hDEAD_BEEF;
        #2;
        tests++; if ({s.psel, grant} !== 3'b000) begin fails++; $display("FAIL rd_c0 psel/grant got=%b/%b exp=0/00", s.psel, grant); end
        cyc(); m0.penable = 1; #2;
        tests++; if ({s.psel, s.penable} !== 2'b10) begin fails++; $display("FAIL rd_c1 psel/penable got=%b%b exp=10", s.psel, s.penable); end
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rd_c1_grant got=%b exp=01", grant); end
        tests++; if ({s.paddr, m0.pready} !== {32'h10, 1'b0}) begin fails++; $display("FAIL rd_c1 paddr/pready got=%h/%b exp=10/0", s.paddr, m0.pready); end
        cyc(); #2;
        tests++; if ({s.psel, s.penable, grant} !== 4'b1101) begin fails++; $display("FAIL rd_c2 psel/penable/grant got=%b%b%b exp=1101", s.psel, s.penable, grant); end
        tests++; if ({m0.pready, m0.pslverr, m0.prdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL rd_c2_rsp got=%b%b%h exp=10deadbeef", m0.pready, m0.pslverr, m0.prdata);
        end
        cyc(); m0.psel = 0; m0.penable = 0; #2;
        tests++; if ({s.psel, grant, m0.pready} !== 4'b0000) begin fails++; $display("FAIL rd_c3_idle got=%b%b%b exp=0000", s.psel, grant, m0.pready); end
    endtask

    task automatic test_contention;
        do_reset();
        m0.psel = 1; m0.pwrite = 1; m0.paddr = 32'h4; m0.pwdata = 32'hA5;
        m1.psel = 1; m1.pwrite = 1; m1.paddr = 32'h8; m1.pwdata = 32'h5A;
        cyc(); m0.penable = 1; m1.penable = 1; #2;
        tests++; if ({grant, s.paddr, s.pwdata, s.pwrite} !== {2'b01, 32'h4, 32'hA5, 1'b1}) begin
            fails++; $display("FAIL ct_first got=%b/%h/%h/%b exp=01/4/a5/1", grant, s.paddr, s.pwdata, s.pwrite);
        end
        cyc(); s.pready = 1; #2;
        tests++; if ({m0.pready, m1.pready} !== 2'b10) begin fails++; $display("FAIL ct_m0_done got=%b%b exp=10", m0.pready, m1.pready); end
        cyc(); m0.psel = 0; m0.penable = 0; #2;
        tests++; if ({s.psel, grant, m1.pready} !== 4'b0000) begin fails++; $display("FAIL ct_gap got=%b%b%b exp=0000", s.psel, grant, m1.pready); end
        cyc(); #2;
        tests++; if ({grant, s.paddr, s.pwdata, m1.pready} !== {2'b10, 32'h8, 32'h5A, 1'b0}) begin
            fails++; $display("FAIL ct_second got=%b/%h/%h/%b exp=10/8/5a/0", grant, s.paddr, s.pwdata, m1.pready);
        end
        cyc(); #2;
        tests++; if ({m1.pready, m0.pready} !== 2'b10) begin fails++; $display("FAIL ct_m1_done got=%b%b exp=10", m1.pready, m0.pready); end
        cyc(); m1.psel = 0; m1.penable = 0;
    endtask

    task automatic test_fairness;
        int left0;
        int left1;
        int done_n;
        int exp_owner;
        do_reset();
        left0 = 4; left1 = 4; done_n = 0; exp_owner = 0;
        s.pready = 1;
        for (int c = 0; c < 60 && done_n < 8; c++) begin
            m0.psel = (left0 > 0); m0.pwrite = 1; m0.paddr = 32'h100 + left0; m0.pwdata = left0;
            m1.psel = (left1 > 0); m1.pwrite = 1; m1.paddr = 32'h200 + left1; m1.pwdata = left1;
            #2;
            if (s.psel && s.penable) begin
                tests++; if (grant !== ((exp_owner != 0) ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL rr_order xfer=%0d got=%b exp_owner=m%0d", done_n, grant, exp_owner);
                end
                tests++; if (s.paddr !== ((exp_owner != 0) ? 32'h200 + left1 : 32'h100 + left0)) begin
                    fails++; $display("FAIL rr_paddr xfer=%0d got=%h", done_n, s.paddr);
                end
                if (m0.pready) left0--;
                if (m1.pready) left1--;
                done_n++;
                exp_owner ^= 1;
            end
            cyc();
        end
        tests++; if (done_n !== 8 || left0 !== 0 || left1 !== 0) begin
            fails++; $display("FAIL rr_count got=%0d left=%0d/%0d exp=8 left=0/0", done_n, left0, left1);
        end
        idle_inputs();
    endtask

    task automatic test_wait_states;
        logic ok;
        do_reset();
        m0.psel = 1; m0.paddr = 32'h20;
        cyc(); m0.penable = 1;
        ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(); m0.paddr = 32'h20 + k; #2;
            if (m0.pready !== 1'b0 || s.paddr !== 32'h20 || s.penable !== 1'b1) ok = 1'b0;
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ws_hold got=%b exp=1", ok); end
        cyc(); s.pready = 1; s.pslverr = 1; s.prdata = 32'h1234; #2;
        tests++; if ({m0.pready, m0.pslverr, m0.prdata, s.paddr} !== {2'b11, 32'h1234, 32'h20}) begin
            fails++; $display("FAIL ws_done got=%b%b%h paddr=%h exp=11 1234 paddr=20", m0.pready, m0.pslverr, m0.prdata, s.paddr);
        end
        cyc(); idle_inputs();
    endtask

    task automatic test_timeout;
        logic ok;
        do_reset();
        m0.psel = 1; m0.paddr = 32'h50; s.prdata = 32'h7777_7777; s.pslverr = 0;
        cyc(); m0.penable = 1;
        ok = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc(); #2;
            if (m0.pready !== 1'b0 || s.penable !== 1'b1) ok = 1'b0;
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL to_early got=%b exp=1", ok); end
        cyc(); #2;
        tests++; if ({m0.pready, m0.pslverr, m0.prdata} !== {2'b11, 32'h0}) begin
            fails++; $display("FAIL to_fire got=%b%b%h exp=11 00000000", m0.pready, m0.pslverr, m0.prdata);
        end
        cyc(); m0.psel = 0; m0.penable = 0; #2;
        tests++; if ({s.psel, grant} !== 3'b000) begin fails++; $display("FAIL to_release got=%b%b exp=000", s.psel, grant); end
        // Same watchdog, no reset: slave answers on the would-be timeout cycle
        m0.psel = 1; m0.paddr = 32'h54;
        cyc(); m0.penable = 1;
        for (int k = 1; k <= 15; k++) cyc();
        cyc(); s.pready = 1; s.pslverr = 0; s.prdata = 32'hCAFE; #2;
        tests++; if ({m0.pready, m0.pslverr, m0.prdata} !== {2'b10, 32'hCAFE}) begin
            fails++; $display("FAIL to_pready_wins got=%b%b%h exp=10 0000cafe", m0.pready, m0.pslverr, m0.prdata);
        end
        cyc(); idle_inputs();
    endtask

    task automatic test_back_to_back;
        do_reset();
        s.pready = 1;
        m1.psel = 1; m1.paddr = 32'h40;
        cyc(); cyc(); #2;
        tests++; if ({m1.pready, grant} !== 3'b110) begin fails++; $display("FAIL b2b_first got=%b%b exp=110", m1.pready, grant); end
        cyc(); m1.paddr = 32'h44; #2;
        tests++; if ({s.psel, grant} !== 3'b000) begin fails++; $display("FAIL b2b_gap got=%b%b exp=000", s.psel, grant); end
        cyc(); #2;
        tests++; if ({grant, s.paddr} !== {2'b10, 32'h44}) begin fails++; $display("FAIL b2b_regrant got=%b/%h exp=10/44", grant, s.paddr); end
        cyc(); #2;
        tests++; if (m1.pready !== 1'b1) begin fails++; $display("FAIL b2b_second got=%b exp=1", m1.pready); end
        cyc(); idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0.psel = 1; m0.paddr = 32'h30;
        cyc(); cyc(); s.pready = 1; #2;
        tests++; if (m0.pready !== 1'b1) begin fails++; $display("FAIL rm_m0 got=%b exp=1", m0.pready); end
        cyc(); m0.psel = 0; s.pready = 0; m1.psel = 1; m1.paddr = 32'h34;
        cyc(); cyc(); #2;
        tests++; if ({s.penable, grant} !== 3'b110) begin fails++; $display("FAIL rm_access got=%b%b exp=110", s.penable, grant); end
        reset = 1'b1; s.pready = 1; #1;
        tests++; if ({s.psel, s.penable, grant, m1.pready} !== 5'b00000) begin
            fails++; $display("FAIL rm_async got=%b%b%b%b exp=00000", s.psel, s.penable, grant, m1.pready);
        end
        idle_inputs();
        cyc(); reset = 1'b0;
        m0.psel = 1; m1.psel = 1;
        cyc(); #2;
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rm_first_contest got=%b exp=01", grant); end
        cyc(); idle_inputs();
    endtask

    task automatic test_no_watchdog;
        z0.psel = 1; z0.paddr = 32'h60;
        repeat (30) cyc();
        #2;
        tests++; if ({zs.psel, zs.penable, z0.pready, grant0} !== 5'b11001) begin
            fails++; $display("FAIL nowd_hang got=%b%b%b%b exp=11001", zs.psel, zs.penable, z0.pready, grant0);
        end
    endtask

    initial begin
        reset = 1'b1;
        reset0 = 1'b1;
        idle_inputs();
        z0.psel = 0; z0.penable = 0; z0.pwrite = 0; z0.paddr = '0; z0.pwdata = '0;
        z1.psel = 0; z1.penable = 0; z1.pwrite = 0; z1.paddr = '0; z1.pwdata = '0;
        zs.pready = 0; zs.pslverr = 0; zs.prdata = '0;
        cyc(); cyc();
        reset0 = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_no_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
